// File: rtl/mac_rr_scheduler_pkg.sv
// Shared parameters and payload types for the round-robin MAC scheduler.
package mac_rr_scheduler_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int DATA_OUT_WIDTH = 16;
    localparam int N_REQ          = 4;
    localparam int MAC_LATENCY    = 2;
    localparam int RESP_DEPTH     = 4;
    localparam int ID_W           = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] c;
    } mac_req_t;

    typedef struct packed {
        logic [ID_W-1:0]           id;
        logic [DATA_OUT_WIDTH-1:0] data;
    } mac_resp_t;

endpackage

// File: rtl/mac_resp_fifo.sv
// Show-ahead response FIFO; the head entry reads as zero while the FIFO is empty.
module mac_resp_fifo
    import mac_rr_scheduler_pkg::*;
#(
    parameter type T     = mac_resp_t,
    parameter int  DEPTH = RESP_DEPTH,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  T              wr_data,
    input  logic          pop,
    output T              rd_data,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_rr_scheduler.sv
// Round-robin sharing of one pipelined MAC between N_REQ requesters, with
// requester tags realigned to the MAC output and credit-gated result buffering.
module mac_rr_scheduler
    import mac_rr_scheduler_pkg::*;
#(
    parameter int N_REQ       = mac_rr_scheduler_pkg::N_REQ,
    parameter int DATA_WIDTH  = mac_rr_scheduler_pkg::DATA_WIDTH,
    parameter int DATA_OUT_W  = mac_rr_scheduler_pkg::DATA_OUT_WIDTH,
    parameter int MAC_LATENCY = mac_rr_scheduler_pkg::MAC_LATENCY,
    parameter int RESP_DEPTH  = mac_rr_scheduler_pkg::RESP_DEPTH,
    localparam int ID_W       = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]  req_a,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]  req_b,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]  req_c,
    output logic [DATA_WIDTH-1:0]             mac_a,
    output logic [DATA_WIDTH-1:0]             mac_b,
    output logic [DATA_WIDTH-1:0]             mac_c,
    input  logic [DATA_OUT_W-1:0]             mac_out,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [ID_W-1:0]                   resp_id,
    output logic [DATA_OUT_W-1:0]             resp_data,
    output logic                              busy
);

    localparam int CW = $clog2(RESP_DEPTH + 1);

    // Handshakes: a transfer happens in any cycle where valid && ready are both
    // high at the rising edge; valid never waits on ready, ready may depend on valid.
    logic [CW-1:0]                    credits;
    logic [ID_W-1:0]                  last_grant;
    logic [ID_W-1:0]                  grant_id;
    logic                             found;
    logic                             can_issue;
    logic                             issue;
    mac_req_t                         issue_req;
    logic [MAC_LATENCY-1:0]           tag_vld;
    logic [MAC_LATENCY-1:0][ID_W-1:0] tag_id;
    logic                             fifo_pop;
    logic [CW-1:0]                    fifo_count;
    mac_resp_t                        push_data;
    mac_resp_t                        head;

    always_comb begin
        int cand;
        cand     = 0;
        grant_id = last_grant;
        found    = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_grant) + k) % N_REQ;
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                grant_id = ID_W'(cand);
            end
        end
    end

    assign can_issue = rst_n && (credits != '0);
    assign issue     = can_issue && found;
    assign req_ready = issue ? (N_REQ'(1) << grant_id) : '0;

    always_comb begin
        issue_req = '0;
        if (issue) begin
            issue_req.a = req_a[grant_id];
            issue_req.b = req_b[grant_id];
            issue_req.c = req_c[grant_id];
        end
    end

    assign mac_a = issue_req.a;
    assign mac_b = issue_req.b;
    assign mac_c = issue_req.c;

    // Stage 0 is loaded on the same edge the MAC captures operands, so the last
    // stage is valid exactly while mac_out carries that operation's result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= issue;
            tag_id[0]  <= grant_id;
            for (int i = 1; i < MAC_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign fifo_pop = resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits    <= CW'(RESP_DEPTH);
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            if (issue && !fifo_pop) begin
                credits <= credits - CW'(1);
            end else if (!issue && fifo_pop) begin
                credits <= credits + CW'(1);
            end
            if (issue) begin
                last_grant <= grant_id;
            end
        end
    end

    assign push_data.id   = tag_id[MAC_LATENCY-1];
    assign push_data.data = mac_out;

    mac_resp_fifo #(
        .T     (mac_resp_t),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (tag_vld[MAC_LATENCY-1]),
        .wr_data (push_data),
        .pop     (fifo_pop),
        .rd_data (head),
        .count   (fifo_count)
    );

    assign resp_valid = (fifo_count != '0);
    assign resp_id    = head.id;
    assign resp_data  = head.data;
    assign busy       = (credits != CW'(RESP_DEPTH));

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Self-checking bench for mac_rr_scheduler with a behavioural two-stage MAC.
module tb_mac_rr_scheduler;

    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int OW    = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int IW    = 2;
    localparam int W     = IW + OW;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0]          req_ready;
    logic [NR-1:0][DW-1:0]  req_a;
    logic [NR-1:0][DW-1:0]  req_b;
    logic [NR-1:0][DW-1:0]  req_c;
    logic [DW-1:0]          mac_a;
    logic [DW-1:0]          mac_b;
    logic [DW-1:0]          mac_c;
    logic [OW-1:0]          mac_out;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [IW-1:0]          resp_id;
    logic [OW-1:0]          resp_data;
    logic                   busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           credits_m = DEPTH;
    int           last_m    = NR - 1;
    logic [OW-1:0] mac_pipe [LAT];

    mac_rr_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_c      (mac_c),
        .mac_out    (mac_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // External MAC: OUT = A*B + C, LAT register stages, never stalls.
    always @(posedge clk) begin
        mac_pipe[0] <= OW'(mac_a) * OW'(mac_b) + OW'(mac_c);
        for (int i = 1; i < LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
    end
    assign mac_out = mac_pipe[LAT-1];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] v, input int last);
        logic [NR-1:0] g;
        g = '0;
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (last + k) % NR;
            if (v[idx] && g == '0) g[idx] = 1'b1;
        end
        return g;
    endfunction

    // Scoreboard: predicts grants, pushes expected results on issue and compares on pop.
    always @(negedge clk) begin : scoreboard
        logic [NR-1:0] exp_rdy;
        logic          exp_rv;
        int            gid;
        if (cyc > 0) begin
            exp_rdy = (rst_n && credits_m > 0) ? model_grant(req_valid, last_m) : '0;
            check("req_ready", req_ready, exp_rdy);
            gid = 0;
            for (int i = 0; i < NR; i++) if (exp_rdy[i]) gid = i;
            if (exp_rdy != '0)
                check("mac_ops", {mac_a, mac_b, mac_c}, {req_a[gid], req_b[gid], req_c[gid]});
            else
                check("mac_idle", {mac_a, mac_b, mac_c}, 0);
            exp_rv = (exp_q.size() > 0) && (due_q[0] <= cyc);
            check("resp_valid", resp_valid, exp_rv);
            if (exp_rv) check("resp", {resp_id, resp_data}, exp_q[0]);
            else        check("resp_zero", {resp_id, resp_data}, 0);
            check("busy", busy, credits_m != DEPTH);
            if (!rst_n) begin
                exp_q.delete();
                due_q.delete();
                credits_m = DEPTH;
                last_m    = NR - 1;
            end else begin
                if (exp_rv && resp_ready) begin
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                    credits_m++;
                end
                if (exp_rdy != '0) begin
                    exp_q.push_back({IW'(gid),
                        OW'(req_a[gid]) * OW'(req_b[gid]) + OW'(req_c[gid])});
                    due_q.push_back(cyc + LAT + 1);
                    credits_m--;
                    last_m = gid;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_ops();
        for (int j = 0; j < NR; j++) begin
            req_a[j] = DW'($urandom_range(0, 255));
            req_b[j] = DW'($urandom_range(0, 255));
            req_c[j] = DW'($urandom_range(0, 255));
        end
    endtask

    task automatic wait_resp(output int at);
        at = -1;
        for (int n = 0; n < 20 && at < 0; n++) begin
            @(negedge clk);
            if (resp_valid) at = cyc;
        end
        if (at < 0) check("resp_timeout", resp_valid, 1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 40 && !idle; n++) begin
            @(negedge clk);
            if (!busy && !resp_valid) idle = 1'b1;
        end
        check("idle", {busy, resp_valid}, 0);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int at;
        int n_iss;

        rst_n      = 1'b0;
        req_valid  = '1;
        resp_ready = 1'b1;
        req_a      = '0;
        req_b      = '0;
        req_c      = '0;

        // Reset with every requester asking.
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", req_ready, 0);
            check("rst_mac", {mac_a, mac_b, mac_c}, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_busy", busy, 0);
        end
        step();
        rst_n     = 1'b1;
        req_valid = '0;
        step();

        // Single operation: 3*4+5 arrives three cycles after issue.
        req_valid = 4'b0001;
        req_a[0]  = 8'd3;
        req_b[0]  = 8'd4;
        req_c[0]  = 8'd5;
        @(negedge clk);
        check("s2_grant", req_ready, 4'b0001);
        t0 = cyc;
        step();
        req_valid = '0;
        wait_resp(at);
        check("s2_latency", at - t0, 3);
        check("s2_id", resp_id, 0);
        check("s2_data", resp_data, 17);
        wait_idle();

        // Fresh reset, then all requesters valid: grants rotate 0,1,2,3,...
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        req_valid = '1;
        randomize_ops();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("s3_grant", req_ready, NR'(1) << (i % NR));
            step();
            randomize_ops();
        end
        req_valid = '0;
        wait_idle();

        // Backpressure: only RESP_DEPTH issues fit, then draining returns credits.
        resp_ready = 1'b0;
        req_valid  = '1;
        randomize_ops();
        n_iss = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_ready != '0) n_iss++;
            step();
            randomize_ops();
        end
        check("s4_issue_count", n_iss, 4);
        @(negedge clk);
        check("s4_stalled", req_ready, 0);
        check("s4_full_valid", resp_valid, 1);
        step();
        resp_ready = 1'b1;
        @(negedge clk);
        check("s4_pop_cycle_no_grant", req_ready, 0);
        step();
        @(negedge clk);
        check("s4_credit_regrant", |req_ready, 1);
        step();
        req_valid = '0;
        wait_idle();

        // Widest operands: 255*255+255 = 65280 with no truncation.
        req_valid = 4'b0100;
        req_a[2]  = 8'd255;
        req_b[2]  = 8'd255;
        req_c[2]  = 8'd255;
        @(negedge clk);
        t0 = cyc;
        step();
        req_valid = '0;
        wait_resp(at);
        check("s5_latency", at - t0, 3);
        check("s5_id", resp_id, 2);
        check("s5_data", resp_data, 65280);
        wait_idle();

        // Reset with two operations in flight discards them.
        req_valid = 4'b1010;
        randomize_ops();
        step();
        step();
        req_valid = '0;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("s6_no_resp", resp_valid, 0);
            check("s6_not_busy", busy, 0);
        end
        step();
        req_valid = '1;
        randomize_ops();
        @(negedge clk);
        check("s6_first_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
